// File: rtl/frame_snapshot_ctrl.sv
// Frame snapshot controller: gates capture-stage pixel writes into the frame buffer, 1-cycle registered latency, no backpressure (writes are dropped, never stalled).
// Build option SNAPSHOT_CSUM_EN adds a 24-bit modulo sum of captured pixel data on o_csum; otherwise o_csum is tied to 0.
module frame_snapshot_ctrl #(
    parameter int FRAME_PIXELS = 307200
) (
    input  logic        i_pclk,
    input  logic        i_reset,
    input  logic [18:0] i_cap_addr,
    input  logic [11:0] i_cap_data,
    input  logic        i_cap_we,
    input  logic        i_live_mode,
    input  logic        i_snap_req,
    input  logic        i_release,
    output logic [18:0] o_fb_addr,
    output logic [11:0] o_fb_data,
    output logic        o_fb_we,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_short_frame,
    output logic [18:0] o_pix_cnt,
    output logic [23:0] o_csum
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    localparam logic [18:0] LP_FRAME = 19'(FRAME_PIXELS);
    localparam logic [18:0] LP_LAST  = 19'(FRAME_PIXELS - 1);

    state_t      r_state;
    state_t      w_next;

    logic [18:0] r_fb_addr;
    logic [11:0] r_fb_data;
    logic        r_fb_we;
    logic        r_busy;
    logic        r_done;
    logic        r_short_frame;
    logic [18:0] r_pix_cnt;

    logic        w_pix_vld;
    logic        w_first;
    logic        w_last;
    logic        w_fwd;
    logic        w_count;
    logic        w_restart;
    logic        w_short;
    logic        w_arm;
    logic        w_done;

    assign w_pix_vld = i_cap_we && (i_cap_addr < LP_FRAME);
    assign w_first   = (i_cap_addr == 19'd0);
    assign w_last    = (i_cap_addr == LP_LAST);

    always_comb begin
        w_next    = r_state;
        w_fwd     = 1'b0;
        w_count   = 1'b0;
        w_restart = 1'b0;
        w_short   = 1'b0;
        w_arm     = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_fwd = w_pix_vld && i_live_mode;
                // A simultaneous release overrides the request and keeps us idle.
                if (i_snap_req && !i_release) begin
                    w_next = S_ARMED;
                    w_arm  = 1'b1;
                end
            end
            S_ARMED: begin
                if (i_release) begin
                    w_next = S_IDLE;
                end else if (w_pix_vld && w_first) begin
                    w_fwd     = 1'b1;
                    w_count   = 1'b1;
                    w_restart = 1'b1;
                    if (w_last) begin
                        w_next = S_HOLD;
                        w_done = 1'b1;
                    end else begin
                        w_next = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (i_release) begin
                    w_next = S_IDLE;
                end else if (w_pix_vld) begin
                    w_fwd     = 1'b1;
                    w_count   = 1'b1;
                    w_restart = w_first;
                    w_short   = w_first;
                    if (w_last) begin
                        w_next = S_HOLD;
                        w_done = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (i_release) begin
                    w_next = S_IDLE;
                end else if (i_snap_req) begin
                    w_next = S_ARMED;
                    w_arm  = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_fb_addr     <= 19'd0;
            r_fb_data     <= 12'd0;
            r_fb_we       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_short_frame <= 1'b0;
            r_pix_cnt     <= 19'd0;
        end else begin
            r_fb_we <= w_fwd;
            if (w_fwd) begin
                r_fb_addr <= i_cap_addr;
                r_fb_data <= i_cap_data;
            end
            r_busy <= (w_next == S_ARMED) || (w_next == S_CAPTURE);
            r_done <= w_done;
            if (w_arm) begin
                r_short_frame <= 1'b0;
            end else if (w_short) begin
                r_short_frame <= 1'b1;
            end
            // Counter saturates at the frame size; repeated addresses can otherwise overrun it.
            if (w_arm) begin
                r_pix_cnt <= 19'd0;
            end else if (w_count) begin
                if (w_restart) begin
                    r_pix_cnt <= 19'd1;
                end else if (r_pix_cnt != LP_FRAME) begin
                    r_pix_cnt <= r_pix_cnt + 19'd1;
                end
            end
        end
    end

`ifdef SNAPSHOT_CSUM_EN
    logic [23:0] r_csum;

    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_csum <= 24'd0;
        end else if (w_arm) begin
            r_csum <= 24'd0;
        end else if (w_count) begin
            if (w_restart) begin
                r_csum <= {12'd0, i_cap_data};
            end else begin
                r_csum <= r_csum + {12'd0, i_cap_data};
            end
        end
    end

    assign o_csum = r_csum;
`else
    assign o_csum = 24'd0;
`endif

    assign o_fb_addr     = r_fb_addr;
    assign o_fb_data     = r_fb_data;
    assign o_fb_we       = r_fb_we;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_short_frame = r_short_frame;
    assign o_pix_cnt     = r_pix_cnt;

endmodule

// File: tb/tb_frame_snapshot_ctrl.sv
// Directed self-checking bench for frame_snapshot_ctrl with a 16-pixel frame.
module tb_frame_snapshot_ctrl;

`ifdef SNAPSHOT_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        pclk;
    logic        reset;
    logic [18:0] cap_addr;
    logic [11:0] cap_data;
    logic        cap_we;
    logic        live_mode;
    logic        snap_req;
    logic        rel;
    logic [18:0] fb_addr;
    logic [11:0] fb_data;
    logic        fb_we;
    logic        busy;
    logic        done;
    logic        short_frame;
    logic [18:0] pix_cnt;
    logic [23:0] csum;

    int n_checks = 0;
    int n_fail   = 0;

    frame_snapshot_ctrl #(.FRAME_PIXELS(16)) dut (
        .i_pclk        (pclk),
        .i_reset       (reset),
        .i_cap_addr    (cap_addr),
        .i_cap_data    (cap_data),
        .i_cap_we      (cap_we),
        .i_live_mode   (live_mode),
        .i_snap_req    (snap_req),
        .i_release     (rel),
        .o_fb_addr     (fb_addr),
        .o_fb_data     (fb_data),
        .o_fb_we       (fb_we),
        .o_busy        (busy),
        .o_done        (done),
        .o_short_frame (short_frame),
        .o_pix_cnt     (pix_cnt),
        .o_csum        (csum)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // One clock: apply inputs, sample 1ns after the edge, then drop the pulse inputs.
    task automatic cyc(input logic we, input logic [18:0] a, input logic [11:0] d);
        cap_we   = we;
        cap_addr = a;
        cap_data = d;
        @(posedge pclk);
        #1;
        cap_we   = 1'b0;
        snap_req = 1'b0;
        rel      = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(1'b1, 19'd3, 12'h123);
        cyc(1'b0, 19'd0, 12'h000);
        n_checks++;
        if ({fb_we, busy, done, short_frame} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000", {fb_we, busy, done, short_frame});
        end
        n_checks++;
        if ({fb_addr, fb_data, pix_cnt, csum} !== 74'd0) begin
            n_fail++;
            $display("FAIL reset_values: got addr=%0h data=%0h cnt=%0d csum=%0h required all 0", fb_addr, fb_data, pix_cnt, csum);
        end
        reset = 1'b0;
        cyc(1'b0, 19'd0, 12'h000);
    endtask

    task automatic test_live;
        live_mode = 1'b1;
        cyc(1'b1, 19'd5, 12'hABC);
        n_checks++;
        if ({fb_we, fb_addr, fb_data} !== {1'b1, 19'd5, 12'hABC}) begin
            n_fail++;
            $display("FAIL live_forward: got we=%b addr=%0d data=%0h required we=1 addr=5 data=abc", fb_we, fb_addr, fb_data);
        end
        cyc(1'b0, 19'd6, 12'h111);
        n_checks++;
        if (fb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL live_idle_we: got %b required 0", fb_we);
        end
        cyc(1'b1, 19'd20, 12'h222);
        n_checks++;
        if (fb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL live_out_of_range: got we=%b required 0", fb_we);
        end
        live_mode = 1'b0;
        cyc(1'b1, 19'd4, 12'h333);
        n_checks++;
        if (fb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_live: got we=%b required 0", fb_we);
        end
    endtask

    task automatic test_arm_sync;
        logic [18:0] a;
        logic        exp_we;
        snap_req = 1'b1;
        cyc(1'b0, 19'd0, 12'h000);
        n_checks++;
        if ({busy, fb_we} !== 2'b10) begin
            n_fail++;
            $display("FAIL armed_busy: got busy=%b we=%b required busy=1 we=0", busy, fb_we);
        end
        for (int i = 0; i < 20; i++) begin
            a      = (i < 6) ? 19'(10 + i) : 19'(i - 6);
            exp_we = (i >= 6);
            cyc(1'b1, a, 12'h100 + 12'(a));
            n_checks++;
            if ({fb_we, busy, done} !== {exp_we, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL sync_step%0d: got we=%b busy=%b done=%b required we=%b busy=1 done=0", i, fb_we, busy, done, exp_we);
            end
            if (exp_we) begin
                n_checks++;
                if ({fb_addr, fb_data} !== {a, 12'h100 + 12'(a)}) begin
                    n_fail++;
                    $display("FAIL sync_data%0d: got addr=%0d data=%0h required addr=%0d data=%0h", i, fb_addr, fb_data, a, 12'h100 + 12'(a));
                end
            end
        end
        n_checks++;
        if (pix_cnt !== 19'd14) begin
            n_fail++;
            $display("FAIL sync_cnt: got %0d required 14", pix_cnt);
        end
        snap_req = 1'b1;
        cyc(1'b1, 19'd14, 12'h001);
        n_checks++;
        if ({pix_cnt, busy, fb_we} !== {19'd15, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL snap_ignored: got cnt=%0d busy=%b we=%b required cnt=15 busy=1 we=1", pix_cnt, busy, fb_we);
        end
        rel = 1'b1;
        cyc(1'b1, 19'd15, 12'h001);
        n_checks++;
        if ({fb_we, done, busy, pix_cnt} !== {1'b0, 1'b0, 1'b0, 19'd15}) begin
            n_fail++;
            $display("FAIL abort: got we=%b done=%b busy=%b cnt=%0d required 0 0 0 15", fb_we, done, busy, pix_cnt);
        end
        cyc(1'b1, 19'd0, 12'h001);
        n_checks++;
        if (fb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got we=%b required 0", fb_we);
        end
    endtask

    task automatic test_full_frame;
        snap_req = 1'b1;
        cyc(1'b0, 19'd0, 12'h000);
        for (int a = 0; a < 16; a++) begin
            cyc(1'b1, 19'(a), 12'h001);
            n_checks++;
            if ({fb_we, done, busy} !== {1'b1, (a == 15), (a != 15)}) begin
                n_fail++;
                $display("FAIL full_step%0d: got we=%b done=%b busy=%b required 1 %b %b", a, fb_we, done, busy, (a == 15), (a != 15));
            end
        end
        n_checks++;
        if ({pix_cnt, csum, short_frame} !== {19'd16, (CSUM_ON ? 24'd16 : 24'd0), 1'b0}) begin
            n_fail++;
            $display("FAIL full_result: got cnt=%0d csum=%0d short=%b required cnt=16 csum=%0d short=0", pix_cnt, csum, short_frame, CSUM_ON ? 16 : 0);
        end
        cyc(1'b1, 19'd3, 12'h001);
        n_checks++;
        if ({fb_we, done, pix_cnt} !== {1'b0, 1'b0, 19'd16}) begin
            n_fail++;
            $display("FAIL hold_frozen: got we=%b done=%b cnt=%0d required 0 0 16", fb_we, done, pix_cnt);
        end
        rel = 1'b1;
        cyc(1'b0, 19'd0, 12'h000);
        n_checks++;
        if ({busy, pix_cnt} !== {1'b0, 19'd16}) begin
            n_fail++;
            $display("FAIL hold_release: got busy=%b cnt=%0d required 0 16", busy, pix_cnt);
        end
    endtask

    task automatic test_short_frame;
        int n_done;
        n_done = 0;
        snap_req = 1'b1;
        cyc(1'b0, 19'd0, 12'h000);
        for (int a = 0; a < 8; a++) begin
            cyc(1'b1, 19'(a), 12'h002);
            n_done += int'(done);
        end
        for (int a = 0; a < 16; a++) begin
            cyc(1'b1, 19'(a), 12'h002);
            n_done += int'(done);
        end
        n_checks++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL short_done_count: got %0d required 1", n_done);
        end
        n_checks++;
        if ({short_frame, pix_cnt, csum} !== {1'b1, 19'd16, (CSUM_ON ? 24'd32 : 24'd0)}) begin
            n_fail++;
            $display("FAIL short_result: got short=%b cnt=%0d csum=%0d required 1 16 %0d", short_frame, pix_cnt, csum, CSUM_ON ? 32 : 0);
        end
        snap_req = 1'b1;
        cyc(1'b0, 19'd0, 12'h000);
        n_checks++;
        if ({short_frame, pix_cnt, csum, busy} !== {1'b0, 19'd0, 24'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL rearm_clear: got short=%b cnt=%0d csum=%0d busy=%b required 0 0 0 1", short_frame, pix_cnt, csum, busy);
        end
        rel = 1'b1;
        cyc(1'b0, 19'd0, 12'h000);
    endtask

    task automatic test_saturate;
        snap_req = 1'b1;
        cyc(1'b0, 19'd0, 12'h000);
        cyc(1'b1, 19'd0, 12'h004);
        for (int i = 0; i < 20; i++) cyc(1'b1, 19'd1, 12'h004);
        n_checks++;
        if ({pix_cnt, busy, done} !== {19'd16, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL saturate: got cnt=%0d busy=%b done=%b required 16 1 0", pix_cnt, busy, done);
        end
        rel = 1'b1;
        cyc(1'b0, 19'd0, 12'h000);
    endtask

    task automatic test_release_priority;
        snap_req = 1'b1;
        rel      = 1'b1;
        cyc(1'b0, 19'd0, 12'h000);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL release_wins: got busy=%b required 0", busy);
        end
        cyc(1'b1, 19'd0, 12'h005);
        n_checks++;
        if (fb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL release_wins_idle: got we=%b required 0", fb_we);
        end
    endtask

    task automatic test_reset_mid;
        int n_done;
        n_done = 0;
        snap_req = 1'b1;
        cyc(1'b0, 19'd0, 12'h000);
        for (int a = 0; a < 7; a++) begin
            cyc(1'b1, 19'(a), 12'h007);
        end
        reset = 1'b1;
        cyc(1'b1, 19'd7, 12'h007);
        n_done += int'(done);
        n_checks++;
        if ({fb_we, busy, done, short_frame, fb_addr, fb_data, pix_cnt, csum} !== 78'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got we=%b busy=%b done=%b short=%b addr=%0d data=%0h cnt=%0d csum=%0d required all 0",
                     fb_we, busy, done, short_frame, fb_addr, fb_data, pix_cnt, csum);
        end
        reset = 1'b0;
        for (int a = 8; a < 16; a++) begin
            cyc(1'b1, 19'(a), 12'h007);
            n_done += int'(done);
        end
        n_checks++;
        if ({n_done, fb_we} !== {32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got done_count=%0d we=%b required 0 0", n_done, fb_we);
        end
        live_mode = 1'b1;
        cyc(1'b1, 19'd20, 12'h008);
        n_checks++;
        if (fb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_range: got we=%b required 0", fb_we);
        end
        cyc(1'b1, 19'd15, 12'h009);
        n_checks++;
        if ({fb_we, fb_addr, fb_data} !== {1'b1, 19'd15, 12'h009}) begin
            n_fail++;
            $display("FAIL reset_mid_live: got we=%b addr=%0d data=%0h required 1 15 009", fb_we, fb_addr, fb_data);
        end
        live_mode = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cap_addr  = 19'd0;
        cap_data  = 12'd0;
        cap_we    = 1'b0;
        live_mode = 1'b0;
        snap_req  = 1'b0;
        rel       = 1'b0;
        #1;
        test_reset();
        test_live();
        test_arm_sync();
        test_full_frame();
        test_short_frame();
        test_saturate();
        test_release_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
